// File: rtl/pc_fetch_unit.sv
// Program-counter register and fetch sequencer with a request/ready handshake to instruction memory.
// Optional fetch/redirect performance counters are built when PC_PERF_CNT_EN is defined.
module pc_fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0010_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] nxt_pc,
  input  logic        advance,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [29:0] pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redir_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [29:0] r_pc;
  logic [31:0] r_instr;
  logic        w_fetch_done;
  logic        w_pc_load;

  assign w_fetch_done = (r_state == S_REQ) && imem_ready;
  assign w_pc_load    = (r_state == S_VALID) && advance && !stall;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_REQ;
      S_REQ:   if (w_fetch_done) w_state_next = S_VALID;
      S_VALID: if (w_pc_load) w_state_next = S_REQ;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decode from state only, so no input reaches an output combinationally.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      S_REQ:   imem_req    = 1'b1;
      S_VALID: instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
    end else begin
      if (w_pc_load)    r_pc    <= nxt_pc;
      if (w_fetch_done) r_instr <= imem_rdata;
    end
  end

  assign pc        = r_pc;
  assign imem_addr = {r_pc, 2'b00};
  assign instr     = r_instr;

`ifdef PC_PERF_CNT_EN
  logic        w_redirect;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redir_cnt;

  // Sequential means exactly pc+1 modulo 2^30, so the top-of-space wrap is not a redirect.
  assign w_redirect = (nxt_pc != (r_pc + 30'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'h0;
      r_redir_cnt <= 32'h0;
    end else begin
      if (w_fetch_done)             r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_pc_load && w_redirect)  r_redir_cnt <= r_redir_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign redir_cnt = r_redir_cnt;
`else
  assign fetch_cnt = 32'h0;
  assign redir_cnt = 32'h0;
`endif

endmodule
